alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//  Combinational integer ALU of the CPU core datapath. Produces a result from two WIDTH-bit
//  operands and a 4-bit op select, with zero latency. Also holds a registered status-flag set
//  (Z/N/C/V) for the branch logic. Sits between the register-file read ports and the writeback mux.
// PARAMETERS
//  WIDTH  16  operand/result width in bits (all arithmetic is unsigned unless stated)
// PORTS
//  clk     in   1      core clock; flags update on rising edge
//  rst     in   1      asynchronous, active-high reset; clears flag register
//  in0     in   WIDTH  operand A
//  in1     in   WIDTH  operand B (also shift amount)
//  select  in   4      op code, see BEHAVIOUR
//  out     out  WIDTH  result, combinational from in0/in1/select
//  zero    out  1      registered: last result == 0
//  neg     out  1      registered: last result MSB
//  carry   out  1      registered: carry/borrow/mul-overflow, see below
//  ovf     out  1      registered: signed overflow (add/sub only)
// BEHAVIOUR
//  Interface: one clock (clk); reset rst is asynchronous and active-high.
//  out is purely combinational. It must settle within the same cycle; no clock involvement.
//  select map, with out truncated to WIDTH bits:
//   0000 ADD  in0+in1          0001 SUB  in0-in1 (two's-complement wrap)
//   0010 MUL  low WIDTH of in0*in1     0011 DIV  unsigned in0/in1; in1==0 -> all ones
//   0100 AND  0101 OR  0110 XOR (bitwise)
//   0111 SHL  in0<<in1, zero fill; in1>=WIDTH -> 0
//   1000 SHR  logical in0>>in1, zero fill; in1>=WIDTH -> 0
//   1011 PASSB  in1            1100 CMP  in0-in1 (same value as SUB)
//   1111 ZERO  0               1001,1010,1101,1110 reserved -> out = 0
//  carry rules:
//   ADD: carry out of MSB. SUB/CMP: borrow (in0<in1 unsigned).
//   MUL: 1 if high WIDTH bits of the full product are nonzero.
//   DIV: 1 on divide-by-zero. All other ops: 0.
//  ovf rules:
//   ADD: operands same sign and result sign differs.
//   SUB/CMP: operands differ in sign and result sign differs from in0. Others: 0.
//  Flag register: on each rising clk, {zero,neg,carry,ovf} <= values computed from the current
//   out/op. The register updates every cycle; there is no enable.
//  Reset: rst=1 forces zero=neg=carry=ovf=0 immediately, regardless of clk.
//   Reset has no effect on out. Flags resume updating on the first clk edge after rst deasserts.
//  Simultaneous operand and select change: out reflects the new inputs after propagation only.
// STRUCTURE
//  alu_pkg: localparam WIDTH default; typedef enum logic[3:0] alu_op_e
//   (OP_ADD..OP_ZERO, reserved codes named OP_RSV*); flag struct alu_flags_t {z,n,c,v}.
//  Sub-module alu_divider: combinational unsigned restoring divider (WIDTH stages),
//   with the divide-by-zero -> all-ones rule inside it.
//  Everything else inline: one always_comb case on select, one always_ff for flags.
// TESTING
//  in0=13,in1=6, sweep select with 2ns settle per op. Required out:
//   ADD 19, SUB 7, MUL 78, DIV 2, AND 4, OR 15, XOR 11, SHL 832, SHR 0, PASSB 6, CMP 7, ZERO 0.
//  Edges:
//   in0=FFFF,in1=1,ADD -> out 0; next clk zero=1,carry=1,ovf=0.
//   in0=7FFF,in1=1,ADD -> ovf=1, neg=1.
//   in0=3,in1=5,SUB -> out FFFE; after clk carry=1, neg=1.
//   in0=1234,in1=0,DIV -> out FFFF, carry=1.
//   in0=1,in1=16,SHL -> 0. in1=15 -> 8000.
//   reserved 1001/1010/1101/1110 -> 0.
//  Reset: with flags set, assert rst between clk edges -> all flags 0 before next edge.
//   out is unchanged while rst is high.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the core-datapath ALU: op codes, flag payload and default width.
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 16;

   typedef enum logic [3:0] {
      OP_ADD   = 4'b0000,
      OP_SUB   = 4'b0001,
      OP_MUL   = 4'b0010,
      OP_DIV   = 4'b0011,
      OP_AND   = 4'b0100,
      OP_OR    = 4'b0101,
      OP_XOR   = 4'b0110,
      OP_SHL   = 4'b0111,
      OP_SHR   = 4'b1000,
      OP_RSV9  = 4'b1001,
      OP_RSVA  = 4'b1010,
      OP_PASSB = 4'b1011,
      OP_CMP   = 4'b1100,
      OP_RSVD  = 4'b1101,
      OP_RSVE  = 4'b1110,
      OP_ZERO  = 4'b1111
   } alu_op_e;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } alu_flags_t;

endpackage

// File: rtl/alu_divider.sv
// Combinational unsigned restoring divider; a zero divisor yields an all-ones quotient.
module alu_divider
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_quotient,
   output logic             o_div_by_zero
);

   logic [WIDTH-1:0] w_rem;
   logic [WIDTH-1:0] w_quo;
   logic [WIDTH:0]   w_trial;

   // One shift-subtract stage per quotient bit, MSB first
   always_comb begin
      w_rem   = '0;
      w_quo   = '0;
      w_trial = '0;
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         w_trial = {w_rem, i_dividend[i]};
         if (w_trial >= {1'b0, i_divisor}) begin
            w_rem    = WIDTH'(w_trial - {1'b0, i_divisor});
            w_quo[i] = 1'b1;
         end else begin
            w_rem = WIDTH'(w_trial);
         end
      end
   end

   assign o_div_by_zero = (i_divisor == '0);
   assign o_quotient    = o_div_by_zero ? '1 : w_quo;

endmodule

// File: rtl/alu.sv
// Zero-latency integer ALU with a registered Z/N/C/V flag set for branch resolution.
module alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [3:0]       select,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             neg,
   output logic             carry,
   output logic             ovf
);

   localparam int unsigned     PW       = 2 * WIDTH;
   localparam logic [WIDTH-1:0] SH_LIMIT = WIDTH'(WIDTH);

   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sub;
   logic [PW-1:0]    w_mul;
   logic [WIDTH-1:0] w_quo;
   logic             w_div_zero;
   logic [WIDTH-1:0] w_out;
   alu_flags_t       w_flags_nxt;
   alu_flags_t       r_flags;

   assign w_add = {1'b0, in0} + {1'b0, in1};
   assign w_sub = {1'b0, in0} - {1'b0, in1};
   assign w_mul = PW'(in0) * PW'(in1);

   alu_divider #(.WIDTH(WIDTH)) u_divider (
      .i_dividend    (in0),
      .i_divisor     (in1),
      .o_quotient    (w_quo),
      .o_div_by_zero (w_div_zero)
   );

   // Result and next-flag selection; carry/ovf default low for non-arithmetic ops
   always_comb begin
      w_out         = '0;
      w_flags_nxt   = '0;
      case (alu_op_e'(select))
         OP_ADD: begin
            w_out         = w_add[WIDTH-1:0];
            w_flags_nxt.c = w_add[WIDTH];
            w_flags_nxt.v = (in0[WIDTH-1] == in1[WIDTH-1]) && (w_add[WIDTH-1] != in0[WIDTH-1]);
         end
         OP_SUB, OP_CMP: begin
            w_out         = w_sub[WIDTH-1:0];
            w_flags_nxt.c = w_sub[WIDTH];
            w_flags_nxt.v = (in0[WIDTH-1] != in1[WIDTH-1]) && (w_sub[WIDTH-1] != in0[WIDTH-1]);
         end
         OP_MUL: begin
            w_out         = w_mul[WIDTH-1:0];
            w_flags_nxt.c = |w_mul[PW-1:WIDTH];
         end
         OP_DIV: begin
            w_out         = w_quo;
            w_flags_nxt.c = w_div_zero;
         end
         OP_AND:   w_out = in0 & in1;
         OP_OR:    w_out = in0 | in1;
         OP_XOR:   w_out = in0 ^ in1;
         OP_SHL:   w_out = (in1 >= SH_LIMIT) ? '0 : (in0 << in1);
         OP_SHR:   w_out = (in1 >= SH_LIMIT) ? '0 : (in0 >> in1);
         OP_PASSB: w_out = in1;
         default:  w_out = '0;
      endcase
      w_flags_nxt.z = (w_out == '0);
      w_flags_nxt.n = w_out[WIDTH-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flags <= '0;
      end else begin
         r_flags <= w_flags_nxt;
      end
   end

   assign out   = w_out;
   assign zero  = r_flags.z;
   assign neg   = r_flags.n;
   assign carry = r_flags.c;
   assign ovf   = r_flags.v;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed vectors push expectations, a monitor pops and compares.
module tb_alu;

   logic        clk;
   logic        rst;
   logic [15:0] in0;
   logic [15:0] in1;
   logic [3:0]  select;
   logic [15:0] out;
   logic        zero;
   logic        neg;
   logic        carry;
   logic        ovf;

   typedef struct {
      bit          is_flag;
      logic [15:0] exp;
      string       name;
   } exp_t;

   exp_t q_exp[$];
   event ev_sample;
   int   checks   = 0;
   int   failures = 0;

   alu dut (
      .clk    (clk),
      .rst    (rst),
      .in0    (in0),
      .in1    (in1),
      .select (select),
      .out    (out),
      .zero   (zero),
      .neg    (neg),
      .carry  (carry),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: on each sample strobe, pop the oldest expectation and compare
   initial begin
      exp_t        e;
      logic [15:0] act;
      forever begin
         @(ev_sample);
         if (q_exp.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_underflow: sample strobe with no expectation queued");
         end else begin
            e   = q_exp.pop_front();
            act = e.is_flag ? {12'h000, zero, neg, carry, ovf} : out;
            checks++;
            if (act !== e.exp) begin
               failures++;
               $display("FAIL %s: got 0x%04h expected 0x%04h", e.name, act, e.exp);
            end
         end
      end
   end

   task automatic push_exp(input bit is_flag, input logic [15:0] exp, input string name);
      exp_t e;
      e.is_flag = is_flag;
      e.exp     = exp;
      e.name    = name;
      q_exp.push_back(e);
   endtask

   task automatic strobe();
      -> ev_sample;
      #1;
   endtask

   // Combinational result check after a 2ns settle
   task automatic do_op(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_out, input string name);
      in0    = a;
      in1    = b;
      select = sel;
      push_exp(1'b0, exp_out, name);
      #2;
      strobe();
   endtask

   // Result check, then flag check {z,n,c,v} one edge later
   task automatic flag_op(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_out, input logic [3:0] exp_f, input string name);
      do_op(sel, a, b, exp_out, name);
      @(posedge clk);
      #1;
      push_exp(1'b1, {12'h000, exp_f}, {name, "_flags"});
      strobe();
   endtask

   initial begin
      rst    = 1'b1;
      in0    = '0;
      in1    = '0;
      select = 4'b1111;
      #2;
      push_exp(1'b1, 16'h0000, "reset_flags");
      strobe();
      @(negedge clk);
      rst = 1'b0;
      #1;

      // Sweep with in0=13, in1=6
      do_op(4'b0000, 16'd13, 16'd6, 16'd19,  "add");
      do_op(4'b0001, 16'd13, 16'd6, 16'd7,   "sub");
      do_op(4'b0010, 16'd13, 16'd6, 16'd78,  "mul");
      do_op(4'b0011, 16'd13, 16'd6, 16'd2,   "div");
      do_op(4'b0100, 16'd13, 16'd6, 16'd4,   "and");
      do_op(4'b0101, 16'd13, 16'd6, 16'd15,  "or");
      do_op(4'b0110, 16'd13, 16'd6, 16'd11,  "xor");
      do_op(4'b0111, 16'd13, 16'd6, 16'd832, "shl");
      do_op(4'b1000, 16'd13, 16'd6, 16'd0,   "shr");
      do_op(4'b1011, 16'd13, 16'd6, 16'd6,   "passb");
      do_op(4'b1100, 16'd13, 16'd6, 16'd7,   "cmp");
      do_op(4'b1111, 16'd13, 16'd6, 16'd0,   "zero_op");

      // Edges; flag nibble is {z,n,c,v}
      flag_op(4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, "add_wrap");
      flag_op(4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, "add_ovf");
      flag_op(4'b0001, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110, "sub_borrow");
      flag_op(4'b0001, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001, "sub_ovf");
      flag_op(4'b1100, 16'h0005, 16'h0005, 16'h0000, 4'b1000, "cmp_equal");
      flag_op(4'b0010, 16'h0100, 16'h0100, 16'h0000, 4'b1010, "mul_high");
      flag_op(4'b0110, 16'hF0F0, 16'h0F0F, 16'hFFFF, 4'b0100, "xor_neg");
      do_op(4'b0011, 16'h1234, 16'h0007, 16'h0299, "div_1234_7");
      do_op(4'b0111, 16'h0001, 16'd16, 16'h0000, "shl_16");
      do_op(4'b0111, 16'h0001, 16'd15, 16'h8000, "shl_15");
      do_op(4'b1000, 16'h8000, 16'd15, 16'h0001, "shr_15");
      do_op(4'b1000, 16'h8000, 16'd20, 16'h0000, "shr_20");
      do_op(4'b1001, 16'h1234, 16'h5678, 16'h0000, "rsv_1001");
      do_op(4'b1010, 16'h1234, 16'h5678, 16'h0000, "rsv_1010");
      do_op(4'b1101, 16'h1234, 16'h5678, 16'h0000, "rsv_1101");
      do_op(4'b1110, 16'h1234, 16'h5678, 16'h0000, "rsv_1110");
      flag_op(4'b0011, 16'h1234, 16'h0000, 16'hFFFF, 4'b0110, "div_by_zero");

      // Mid-cycle async reset with flags set; out must hold its value
      @(negedge clk);
      rst = 1'b1;
      #1;
      push_exp(1'b1, 16'h0000, "async_rst_flags");
      strobe();
      push_exp(1'b0, 16'hFFFF, "rst_out_hold");
      strobe();
      rst = 1'b0;
      @(posedge clk);
      #1;
      push_exp(1'b1, {12'h000, 4'b0110}, "flags_resume");
      strobe();

      // Drain bound: every queued expectation must have been consumed
      for (int i = 0; i < 20 && q_exp.size() != 0; i++) #1;
      if (q_exp.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d expectations left, required 0", q_exp.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
